serial_in_parallel_out_sipo_deserializer: RTL and testbench
===========================================================

Name: serial_in_parallel_out_sipo_deserializer

Overview:
- Receive-side counterpart of the 16-bit PISO shift register.
- Samples a serial bit stream, MSB first, on qualified clock edges and assembles DATA_WIDTH-bit words.
- Presents each completed word in a holding register with a valid/acknowledge handshake. The PISO can therefore feed it directly in loop-back benches and serial links.
- Double-buffered: the next word is assembled while the previous word waits to be read.

Parameters:
- DATA_WIDTH, 16, word width in bits; legal values are ≥2.
- COUNT_WIDTH, $clog2(DATA_WIDTH), width of the bit counter (derived; do not override).

Ports:
- Clk_In  in  1  single clock; all state updates on the rising edge.
- Reset_In  in  1  synchronous, active-high reset.
- Enable_In  in  1  block enable; when low, all state is frozen.
- Clear_In  in  1  aborts the partial frame and clears the error flag (resync).
- Shift_Data_Signal_In  in  1  qualifies Serial_Data_In; one bit is taken per edge while high.
- Serial_Data_In  in  1  serial data, MSB of the word first.
- Read_Ack_In  in  1  consumer acknowledges the word currently on Parallel_Data_Out.
- Parallel_Data_Out  out  DATA_WIDTH  last completed word (holding register).
- Data_Valid_Out  out  1  Parallel_Data_Out holds an unread word.
- Overrun_Error_Out  out  1  sticky: an unread word was overwritten.
- Busy_Out  out  1  a partial frame is in progress (state RECEIVING).
- Bit_Count_Out  out  COUNT_WIDTH  number of bits collected in the current frame.

Behaviour:
- Reset values (Reset_In high at an edge): every output is 0, the internal shift register is 0, and the state is IDLE.
- Priority per edge, highest first: Reset_In, then !Enable_In (hold everything), then Clear_In, then normal operation.
- Outputs are always driven, including when Enable_In is low. They are never Z.
- Shift: when Enable_In and Shift_Data_Signal_In are high, r_Shift = {r_Shift[W-2:0], Serial_Data_In} and Bit_Count increments.
- State machine, 2 states:
  - IDLE: Bit_Count = 0 and Busy_Out = 0. The first shift moves to RECEIVING with Bit_Count = 1.
  - RECEIVING: each shift increments Bit_Count. The shift that supplies bit W-1, i.e. the final LSB with Bit_Count = W-1 before the edge, completes the word:
    - Parallel_Data_Out is loaded with {r_Shift[W-2:0], Serial_Data_In}.
    - Data_Valid_Out is set to 1.
    - Bit_Count wraps to 0 and the state returns to IDLE on that same edge.
- Latency: the word and Data_Valid_Out are visible immediately after the edge that samples the LSB. No extra pipeline stage.
- Back-to-back frames: shifting continues with no gap cycle. The first bit of the next frame can be taken on the edge right after completion.
- Handshake: Read_Ack_In high at an edge while Data_Valid_Out = 1 clears Data_Valid_Out. Parallel_Data_Out holds its value after the ack.
  - Read_Ack_In while Data_Valid_Out = 0 is ignored.
- Completion with Read_Ack_In on the same edge: the new word is loaded, Data_Valid_Out stays 1, and there is no overrun.
- Completion while Data_Valid_Out = 1 and no Read_Ack_In:
  - The new word overwrites Parallel_Data_Out.
  - Data_Valid_Out stays 1.
  - Overrun_Error_Out is set to 1 and stays set until Reset_In or Clear_In.
- Clear_In (with Enable_In high):
  - r_Shift = 0, Bit_Count = 0, state IDLE, Overrun_Error_Out = 0.
  - Parallel_Data_Out and Data_Valid_Out are unchanged.
  - Any shift on the same edge is discarded.
  - Read_Ack_In on the same edge is still honoured.
- Enable_In low: shift, clear and ack are all ignored. A partial frame resumes where it stopped when Enable_In returns high.
- Reset mid-frame: the partial bits are lost and the pending word is dropped (Data_Valid_Out = 0).
- Shift_Data_Signal_In low with Enable_In high: hold; the ack is still processed.

Test Plan:
- Reset, then idle for 4 cycles -> Parallel_Data_Out = 0x0000, Data_Valid_Out = 0, Busy_Out = 0, Bit_Count_Out = 0.
- PISO loop-back: load 0xA5C3 into the PISO, then 16 shifts with Serial_Data_Out wired to Serial_Data_In -> after the 16th edge Parallel_Data_Out = 0xA5C3, Data_Valid_Out = 1, Busy_Out = 0. Ack -> Data_Valid_Out = 0 and the data holds 0xA5C3.
- Back-to-back 0x1234 then 0xBEEF, 32 continuous shifts, with an ack on the same edge as the second word's completion -> 0xBEEF is valid and Overrun_Error_Out = 0. Repeat without the ack -> Overrun_Error_Out = 1.
- Shift 7 bits of 0xFFFF, pulse Clear_In, then shift 16 bits of 0x00FF -> Parallel_Data_Out = 0x00FF and Bit_Count_Out = 0. The partial bits do not leak into the word.
- Shift 5 bits, drop Enable_In for 3 cycles while toggling Shift and Serial inputs, then restore it and shift the remaining 11 bits of 0x8001 -> word = 0x8001 and Bit_Count_Out reads 5 throughout the freeze.
- With a word pending plus 9 partial bits, assert Reset_In for 1 cycle -> all outputs 0. A subsequent full frame of 0x5A5A then completes correctly.

Source files
------------

// File: rtl/serial_in_parallel_out_sipo_deserializer.sv
// Serial-in / parallel-out deserializer, MSB first, with a double-buffered
// holding register, valid/ack handshake and a sticky overrun flag.
module serial_in_parallel_out_sipo_deserializer #(
   parameter int DATA_WIDTH  = 16,
   parameter int COUNT_WIDTH = $clog2(DATA_WIDTH)
) (
   input  logic                   Clk_In,
   input  logic                   Reset_In,
   input  logic                   Enable_In,
   input  logic                   Clear_In,
   input  logic                   Shift_Data_Signal_In,
   input  logic                   Serial_Data_In,
   input  logic                   Read_Ack_In,
   output logic [DATA_WIDTH-1:0]  Parallel_Data_Out,
   output logic                   Data_Valid_Out,
   output logic                   Overrun_Error_Out,
   output logic                   Busy_Out,
   output logic [COUNT_WIDTH-1:0] Bit_Count_Out
);

   typedef enum logic {IDLE, RECEIVING} state_t;

   localparam logic [COUNT_WIDTH-1:0] LAST_CNT = COUNT_WIDTH'(DATA_WIDTH - 1);

   state_t                 r_State;
   state_t                 w_State_Next;
   logic [DATA_WIDTH-1:0]  r_Shift;
   logic [DATA_WIDTH-1:0]  r_Data;
   logic                   r_Valid;
   logic                   r_Overrun;
   logic [COUNT_WIDTH-1:0] r_Bit_Count;

   logic [DATA_WIDTH-1:0]  w_Shift_Next;
   logic                   w_Shift;
   logic                   w_Last;
   logic                   w_Complete;
   logic                   w_Ack;

   // Next-state and per-edge qualifiers; a clear swallows any shift on the same edge.
   always_comb begin
      w_State_Next = r_State;
      w_Shift_Next = {r_Shift[DATA_WIDTH-2:0], Serial_Data_In};
      w_Shift      = Shift_Data_Signal_In && !Clear_In;
      w_Last       = (r_Bit_Count == LAST_CNT);
      w_Complete   = w_Shift && w_Last;
      w_Ack        = Read_Ack_In && r_Valid;
      if (Clear_In) begin
         w_State_Next = IDLE;
      end else if (w_Shift) begin
         case (r_State)
            IDLE:      w_State_Next = RECEIVING;
            RECEIVING: w_State_Next = w_Last ? IDLE : RECEIVING;
            default:   w_State_Next = IDLE;
         endcase
      end
   end

   // State register; frozen while disabled.
   always_ff @(posedge Clk_In) begin
      if (Reset_In)       r_State <= IDLE;
      else if (Enable_In) r_State <= w_State_Next;
   end

   // Shift register, bit counter, holding register and handshake flags.
   always_ff @(posedge Clk_In) begin
      if (Reset_In) begin
         r_Shift     <= '0;
         r_Data      <= '0;
         r_Valid     <= 1'b0;
         r_Overrun   <= 1'b0;
         r_Bit_Count <= '0;
      end else if (Enable_In) begin
         if (Clear_In) begin
            r_Shift     <= '0;
            r_Bit_Count <= '0;
            r_Overrun   <= 1'b0;
         end else if (w_Shift) begin
            r_Shift     <= w_Shift_Next;
            r_Bit_Count <= w_Last ? '0 : r_Bit_Count + COUNT_WIDTH'(1);
         end
         // Completion wins over the ack; an ack on the same edge only
         // suppresses the overrun because the old word counts as read.
         if (w_Complete) begin
            r_Data  <= w_Shift_Next;
            r_Valid <= 1'b1;
            if (r_Valid && !Read_Ack_In) r_Overrun <= 1'b1;
         end else if (w_Ack) begin
            r_Valid <= 1'b0;
         end
      end
   end

   assign Parallel_Data_Out = r_Data;
   assign Data_Valid_Out    = r_Valid;
   assign Overrun_Error_Out = r_Overrun;
   assign Busy_Out          = (r_State == RECEIVING);
   assign Bit_Count_Out     = r_Bit_Count;

endmodule

// File: tb/tb_serial_in_parallel_out_sipo_deserializer.sv
// Directed bench for the SIPO deserializer; expected values are hand-computed.
module tb_serial_in_parallel_out_sipo_deserializer;

   logic        Clk_In = 1'b0;
   logic        Reset_In = 1'b1;
   logic        Enable_In = 1'b1;
   logic        Clear_In = 1'b0;
   logic        Shift_Data_Signal_In = 1'b0;
   logic        Serial_Data_In = 1'b0;
   logic        Read_Ack_In = 1'b0;
   logic [15:0] Parallel_Data_Out;
   logic        Data_Valid_Out;
   logic        Overrun_Error_Out;
   logic        Busy_Out;
   logic [3:0]  Bit_Count_Out;

   int n_cmp = 0;
   int n_err = 0;

   serial_in_parallel_out_sipo_deserializer #(.DATA_WIDTH(16)) dut (
      .Clk_In              (Clk_In),
      .Reset_In            (Reset_In),
      .Enable_In           (Enable_In),
      .Clear_In            (Clear_In),
      .Shift_Data_Signal_In(Shift_Data_Signal_In),
      .Serial_Data_In      (Serial_Data_In),
      .Read_Ack_In         (Read_Ack_In),
      .Parallel_Data_Out   (Parallel_Data_Out),
      .Data_Valid_Out      (Data_Valid_Out),
      .Overrun_Error_Out   (Overrun_Error_Out),
      .Busy_Out            (Busy_Out),
      .Bit_Count_Out       (Bit_Count_Out)
   );

   always #5 Clk_In = ~Clk_In;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge Clk_In);
      #1;
   endtask

   // Shift bits w[hi] down to w[lo] on consecutive edges; optional ack on the last one.
   task automatic send(input logic [15:0] w, input int hi, input int lo, input logic ack_last);
      for (int i = hi; i >= lo; i--) begin
         Shift_Data_Signal_In = 1'b1;
         Serial_Data_In       = w[i];
         Read_Ack_In          = ack_last && (i == lo);
         tick();
      end
      Shift_Data_Signal_In = 1'b0;
      Read_Ack_In          = 1'b0;
   endtask

   task automatic ack();
      Read_Ack_In = 1'b1;
      tick();
      Read_Ack_In = 1'b0;
   endtask

   initial begin
      logic [15:0] piso;

      // Reset, then idle.
      tick(); tick();
      chk("rst_data", Parallel_Data_Out, 16'h0000);
      chk("rst_valid", Data_Valid_Out, 0);
      Reset_In = 1'b0;
      repeat (4) tick();
      chk("idle_data", Parallel_Data_Out, 16'h0000);
      chk("idle_valid", Data_Valid_Out, 0);
      chk("idle_busy", Busy_Out, 0);
      chk("idle_cnt", Bit_Count_Out, 0);
      chk("idle_ovr", Overrun_Error_Out, 0);

      // PISO loop-back: MSB of the PISO register drives the serial line.
      piso = 16'hA5C3;
      for (int i = 0; i < 16; i++) begin
         Shift_Data_Signal_In = 1'b1;
         Serial_Data_In       = piso[15];
         tick();
         piso = piso << 1;
         if (i == 0) chk("lb_busy1", Busy_Out, 1);
         if (i == 14) chk("lb_cnt15", Bit_Count_Out, 15);
      end
      Shift_Data_Signal_In = 1'b0;
      chk("lb_data", Parallel_Data_Out, 16'hA5C3);
      chk("lb_valid", Data_Valid_Out, 1);
      chk("lb_busy", Busy_Out, 0);
      chk("lb_cnt", Bit_Count_Out, 0);
      ack();
      chk("lb_ack_valid", Data_Valid_Out, 0);
      chk("lb_ack_data", Parallel_Data_Out, 16'hA5C3);
      ack();
      chk("ack_idle_valid", Data_Valid_Out, 0);

      // Back-to-back with ack on the second completion.
      send(16'h1234, 15, 0, 1'b0);
      chk("b2b_w1", Parallel_Data_Out, 16'h1234);
      send(16'hBEEF, 15, 0, 1'b1);
      chk("b2b_w2", Parallel_Data_Out, 16'hBEEF);
      chk("b2b_valid", Data_Valid_Out, 1);
      chk("b2b_ovr", Overrun_Error_Out, 0);
      ack();
      // Same again without the ack: second word overruns the first.
      send(16'h1234, 15, 0, 1'b0);
      chk("ovr_w1_ovr", Overrun_Error_Out, 0);
      send(16'hBEEF, 15, 0, 1'b0);
      chk("ovr_data", Parallel_Data_Out, 16'hBEEF);
      chk("ovr_valid", Data_Valid_Out, 1);
      chk("ovr_flag", Overrun_Error_Out, 1);

      // Partial frame then clear (with a shift and an ack on the same edge).
      send(16'hFFFF, 15, 9, 1'b0);
      chk("clr_pre_cnt", Bit_Count_Out, 7);
      chk("clr_pre_busy", Busy_Out, 1);
      Clear_In = 1'b1; Shift_Data_Signal_In = 1'b1; Serial_Data_In = 1'b1; Read_Ack_In = 1'b1;
      tick();
      Clear_In = 1'b0; Shift_Data_Signal_In = 1'b0; Read_Ack_In = 1'b0;
      chk("clr_cnt", Bit_Count_Out, 0);
      chk("clr_busy", Busy_Out, 0);
      chk("clr_ovr", Overrun_Error_Out, 0);
      chk("clr_valid", Data_Valid_Out, 0);
      chk("clr_data", Parallel_Data_Out, 16'hBEEF);
      send(16'h00FF, 15, 0, 1'b0);
      chk("clr_word", Parallel_Data_Out, 16'h00FF);
      chk("clr_word_cnt", Bit_Count_Out, 0);
      chk("clr_word_valid", Data_Valid_Out, 1);
      ack();

      // Freeze mid-frame; clear/shift/serial toggles must be ignored.
      send(16'h8001, 15, 11, 1'b0);
      Enable_In = 1'b0;
      for (int i = 0; i < 3; i++) begin
         Shift_Data_Signal_In = i[0] ? 1'b0 : 1'b1;
         Serial_Data_In       = i[0];
         Clear_In             = (i == 1);
         tick();
         chk("frz_cnt", Bit_Count_Out, 5);
         chk("frz_busy", Busy_Out, 1);
      end
      Enable_In = 1'b1; Clear_In = 1'b0;
      send(16'h8001, 10, 0, 1'b0);
      chk("frz_word", Parallel_Data_Out, 16'h8001);
      chk("frz_valid", Data_Valid_Out, 1);

      // Reset mid-frame with a pending word.
      send(16'h5A5A, 15, 7, 1'b0);
      chk("mrst_pre_cnt", Bit_Count_Out, 9);
      Reset_In = 1'b1;
      tick();
      Reset_In = 1'b0;
      chk("mrst_data", Parallel_Data_Out, 16'h0000);
      chk("mrst_valid", Data_Valid_Out, 0);
      chk("mrst_busy", Busy_Out, 0);
      chk("mrst_cnt", Bit_Count_Out, 0);
      chk("mrst_ovr", Overrun_Error_Out, 0);
      send(16'h5A5A, 15, 0, 1'b0);
      chk("post_word", Parallel_Data_Out, 16'h5A5A);
      chk("post_valid", Data_Valid_Out, 1);
      chk("post_ovr", Overrun_Error_Out, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
